keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad by driving rows active-low and reading columns active-low through pull-ups. Each column sample is debounced. Every debounced key press is emitted as a 4-bit code over a valid/ready handshake. The block is the input-side counterpart of the board's multiplexed seven-segment output path, and its codes typically feed the digit registers that drive the display.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/timer_parameter.sv | 22 ++
 rtl/keypad_scanner.sv | 145 ++++++++++++++
 tb/tb_keypad_scanner.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner and its display-side consumers.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        HOLD     = 2'd3
    } kp_state_e;

    // Index of the lowest active-low bit; the caller guarantees at least one is low.
    function automatic logic [1:0] lowest_low(input logic [COLS-1:0] v);
        lowest_low = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!v[i]) lowest_low = 2'(i);
        end
    endfunction

    // Printed legend for a key code: rows are "1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D",
    // with '*' shown as E and '#' shown as F on the display.
    function automatic logic [3:0] key_label(input logic [3:0] code);
        case (code)
            4'd0:    key_label = 4'h1;
            4'd1:    key_label = 4'h2;
            4'd2:    key_label = 4'h3;
            4'd3:    key_label = 4'hA;
            4'd4:    key_label = 4'h4;
            4'd5:    key_label = 4'h5;
            4'd6:    key_label = 4'h6;
            4'd7:    key_label = 4'hB;
            4'd8:    key_label = 4'h7;
            4'd9:    key_label = 4'h8;
            4'd10:   key_label = 4'h9;
            4'd11:   key_label = 4'hC;
            4'd12:   key_label = 4'hE;
            4'd13:   key_label = 4'h0;
            4'd14:   key_label = 4'hF;
            default: key_label = 4'hD;
        endcase
    endfunction

endpackage

// File: rtl/timer_parameter.sv
// Free-running modulo counter; done pulses for one cycle every FINAL_VALUE+1 enabled cycles.
module timer_parameter #(
    parameter int FINAL_VALUE = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic done
);

    localparam int W = (FINAL_VALUE > 0) ? $clog2(FINAL_VALUE + 1) : 1;

    logic [W-1:0] cnt;

    assign done = enable && (cnt == W'(FINAL_VALUE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    cnt <= '0;
        else if (enable) cnt <= done ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, per-slot debounce, one valid/ready code per press.
// Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_SCANS slots.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 100_000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 50
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [ROWS-1:0] row,
    input  logic [COLS-1:0] col,
    output logic [3:0]      key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held
);

    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_SCANS must be 1..15");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_SCANS must be >= 1");
    end

    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    logic tick;

    timer_parameter #(
        .FINAL_VALUE(SCAN_TICKS - 1)
    ) u_scan_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (1'b1),
        .done   (tick)
    );

    logic [COLS-1:0] col_m, col_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_m <= '1;
            col_s <= '1;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    kp_state_e  state, state_nxt;
    logic [1:0] r, r_nxt;
    logic [1:0] c, c_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic any_low, col_hit;
    assign any_low = !(&col_s);
    // A lower column going low takes priority, so it breaks the match on c.
    assign col_hit = !col_s[c] && (lowest_low(col_s) == c);

`ifdef KEYPAD_REPEAT_EN
    localparam int          RW       = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_SCANS - 1);

    logic [RW-1:0] rpt_cnt;

    // Counts held slots since the last accepted code; any released sample restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       rpt_cnt <= '0;
        else if (state == EMIT && key_ready) rpt_cnt <= '0;
        else if (state == HOLD && tick)      rpt_cnt <= col_s[c] ? '0 : rpt_cnt + RW'(1);
    end
`endif

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        c_nxt     = c;
        cnt_nxt   = cnt;
        unique case (state)
            SCAN: if (tick) begin
                if (any_low) begin
                    c_nxt     = lowest_low(col_s);
                    cnt_nxt   = 4'd1;
                    state_nxt = (DB == 4'd1) ? EMIT : DEBOUNCE;
                end else begin
                    r_nxt = r + 2'd1;
                end
            end
            DEBOUNCE: if (tick) begin
                if (col_hit) begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt + 4'd1 == DB) state_nxt = EMIT;
                end else begin
                    state_nxt = SCAN;
                    r_nxt     = r + 2'd1;
                    cnt_nxt   = '0;
                end
            end
            EMIT: if (key_ready) begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
            end
            HOLD: if (tick) begin
                if (col_s[c]) begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt + 4'd1 == DB) begin
                        state_nxt = SCAN;
                        r_nxt     = r + 2'd1;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
                    if (rpt_cnt == RPT_LAST) state_nxt = EMIT;
`endif
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    // Row drive is registered from the next row index so the pins never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCAN;
            r     <= '0;
            c     <= '0;
            cnt   <= '0;
            row   <= 4'b1110;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
            c     <= c_nxt;
            cnt   <= cnt_nxt;
            row   <= ~(4'b0001 << r_nxt);
        end
    end

    assign key_valid = (state == EMIT);
    assign key_held  = (state == EMIT) || (state == HOLD);
    assign key_code  = key_held ? {r, c} : 4'd0;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix on the row/col pins.
module tb_keypad_scanner;

    localparam int ST = 4;
    localparam int DS = 3;
    localparam int RS = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_ready = 1'b0;
    logic [3:0] row, col, key_code;
    logic       key_valid, key_held;

    logic [3:0][3:0] press = '0;   // [row][col]
    logic [3:0]      exp_q[$];
    logic [3:0]      obs_q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              cyc;

    keypad_scanner #(
        .SCAN_TICKS    (ST),
        .DEBOUNCE_SCANS(DS),
        .REPEAT_SCANS  (RS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its column to its row while that row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r][c] && !row[r]) col[c] = 1'b0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (reset_n && key_valid && key_ready) obs_q.push_back(key_code);
    end

    task automatic slot_start;
        do begin
            @(posedge clk);
            #1;
        end while (cyc % ST != 0);
    endtask

    task automatic wait_held(input logic lvl, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (key_held === lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_row(input logic [3:0] v, input bit eq, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((row === v) == eq) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        bit ok;
        logic [3:0] er;
        reset_n = 1'b0; press = '0; key_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (row !== 4'b1110) begin n_err++; $display("FAIL reset_row: got %b want 1110", row); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d want 0", key_code); end
        n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held: got %b want 0", key_held); end
        reset_n = 1'b1;
        wait_row(4'b1110, 1'b0, 10, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL scan_start: row stuck at %b", row); end
        for (int k = 1; k <= 8; k++) begin
            er = ~(4'b0001 << 2'(k % 4));
            n_cmp++; if (row !== er) begin n_err++; $display("FAIL scan_row%0d: got %b want %b", k, row, er); end
            repeat (ST) @(negedge clk);
        end
    endtask

    task automatic test_press;
        bit ok;
        int lat;
        logic [3:0] e, o;
        key_ready = 1'b1;
        wait_row(4'b1011, 1'b0, 40, ok);
        wait_row(4'b1011, 1'b1, 40, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL press_row2: row 2 never driven, row=%b", row); end
        press[2][1] = 1'b1;
        exp_q.push_back(4'd9);
        lat = 0;
        while (lat < 100 && key_valid !== 1'b1) begin @(negedge clk); lat++; end
        n_cmp++; if (lat != DS * ST) begin n_err++; $display("FAIL press_latency: got %0d cycles want %0d", lat, DS * ST); end
        repeat (8) @(negedge clk);
        n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL press_held: got %b want 1", key_held); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL press_pulse: valid %b want 0 after accept", key_valid); end
        press[2][1] = 1'b0;
        wait_held(1'b0, 100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL press_release: key_held never dropped"); end
        n_cmp++; if (row !== 4'b0111) begin n_err++; $display("FAIL press_resume: row %b want 0111", row); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL press_count: got %0d codes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL press_code: got %0d want %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bounce;
        bit ok;
        logic [3:0] e, o;
        key_ready = 1'b1;
        for (int s = 0; s < 16; s++) begin
            slot_start();
            press[2][1] = (s % 2 == 0);
        end
        slot_start();
        press[2][1] = 1'b0;
        for (int g = 0; g < 8; g++) begin
            slot_start();
            repeat (g % 3) begin @(posedge clk); #1; end
            press[2][1] = 1'b1;
            @(posedge clk); #1;
            press[2][1] = 1'b0;
        end
        repeat (3 * ST) @(negedge clk);
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL bounce_emit: got %0d codes want 0", obs_q.size()); end
        obs_q.delete();
        exp_q.push_back(4'd9);
        press[2][1] = 1'b1;
        wait_held(1'b1, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bounce_steady: steady press never accepted"); end
        repeat (4) @(negedge clk);
        press[2][1] = 1'b0;
        wait_held(1'b0, 100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bounce_release: key_held never dropped"); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL bounce_count: got %0d codes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL bounce_code: got %0d want %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_ready_low;
        bit ok;
        logic [3:0] e, o;
        key_ready = 1'b0;
        press[2][1] = 1'b1;
        exp_q.push_back(4'd9);
        wait_valid(200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_valid: key_valid never rose"); end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) press[2][1] = 1'b0;
            n_cmp++;
            if (key_valid !== 1'b1 || key_code !== 4'd9) begin
                n_err++; $display("FAIL stall_hold%0d: valid=%b code=%0d want valid=1 code=9", i, key_valid, key_code);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        key_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL stall_accept: valid %b want 1 before edge", key_valid); end
        @(negedge clk);
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL stall_drop: valid %b want 0 after accept", key_valid); end
        wait_held(1'b0, 100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_release: key_held never dropped"); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall_count: got %0d codes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL stall_code: got %0d want %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_multi_key;
        bit ok;
        logic [3:0] e, o;
        key_ready = 1'b1;
        press[0][1] = 1'b1;
        press[0][3] = 1'b1;
        exp_q.push_back(4'd1);
        wait_held(1'b1, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL multi_accept: key never accepted"); end
`ifdef KEYPAD_REPEAT_EN
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd1);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (obs_q.size() >= 3) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL multi_repeat: got %0d codes want 3", obs_q.size()); end
`else
        repeat (8) @(negedge clk);
`endif
        press[0][1] = 1'b0;
        press[0][3] = 1'b0;
        wait_held(1'b0, 100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL multi_release: key_held never dropped"); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL multi_count: got %0d codes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL multi_code: got %0d want %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid;
        bit ok;
        key_ready = 1'b0;
        press[2][1] = 1'b1;
        wait_valid(200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_valid: key_valid never rose"); end
        reset_n = 1'b0;
        press = '0;
        #1;
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b want 0", key_valid); end
        n_cmp++; if (row !== 4'b1110) begin n_err++; $display("FAIL rst_async_row: got %b want 1110", row); end
        n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL rst_async_held: got %b want 0", key_held); end
        n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL rst_async_code: got %0d want 0", key_code); end
        @(negedge clk);
        reset_n = 1'b1;
        key_ready = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rst_stale: got %0d codes after reset want 0", obs_q.size()); end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_ready_low();
        test_multi_key();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
